// File: rtl/xor_nn_pkg.sv
// Shared constants, FSM state encoding and widths for the XOR network BIST.
package xor_nn_pkg;
  localparam int PAT_W = 3;
  localparam int Q_W   = 16;

  localparam logic signed [Q_W-1:0] ZERO       = 16'sh0000;
  localparam logic signed [Q_W-1:0] ONE        = 16'sh0100;
  localparam logic signed [Q_W-1:0] THRESH_DEF = 16'sh0080;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;
endpackage

// File: rtl/xor_nn_bist_check.sv
// Decodes the Q8.8 network output against the threshold and compares it with
// the XOR of the current input pattern.
module xor_nn_bist_check
  import xor_nn_pkg::*;
#(
  parameter logic signed [Q_W-1:0] THRESH = THRESH_DEF
) (
  input  logic [PAT_W-1:0]        pattern,
  input  logic signed [Q_W-1:0]   result,
  output logic                    mismatch
);
  logic decoded;
  logic expected;

  // Both operands signed, so negative outputs decode as 0.
  assign decoded  = (result > THRESH);
  assign expected = ^pattern;
  assign mismatch = decoded ^ expected;
endmodule

// File: rtl/xor_nn_bist.sv
// Built-in self test for a 3-input XOR neural network: walks all 8 input
// patterns, lets the output settle, and records failing patterns.
// Optional raw-result capture buffer enabled by XOR_BIST_CAPTURE_EN.
module xor_nn_bist
  import xor_nn_pkg::*;
#(
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic signed [Q_W-1:0] THRESH        = THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic signed [Q_W-1:0] a,
  output logic signed [Q_W-1:0] b,
  output logic signed [Q_W-1:0] c,
  input  logic signed [Q_W-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_mask,
`ifdef XOR_BIST_CAPTURE_EN
  input  logic [PAT_W-1:0]      cap_addr,
  output logic signed [Q_W-1:0] cap_data,
`endif
  output logic [3:0]            fail_count
);
  state_e                state_q, state_d;
  logic [PAT_W-1:0]      pat_q, pat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic signed [Q_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0]            mask_q, mask_d;
  logic [3:0]            fcnt_q, fcnt_d;
  logic                  mismatch;

  xor_nn_bist_check #(.THRESH(THRESH)) u_check (
    .pattern  (pat_q),
    .result   (result),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      a_q     <= ZERO;
      b_q     <= ZERO;
      c_q     <= ZERO;
      mask_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mask_q  <= mask_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mask_d  = mask_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          pat_d   = '0;
          mask_d  = '0;
          fcnt_d  = '0;
        end
      end
      S_APPLY: begin
        a_d     = pat_q[2] ? ONE : ZERO;
        b_d     = pat_q[1] ? ONE : ZERO;
        c_d     = pat_q[0] ? ONE : ZERO;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          mask_d[pat_q] = 1'b1;
          fcnt_d        = fcnt_q + 4'd1;
        end
        if (pat_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          pat_d   = pat_q + 3'd1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign busy       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (mask_q == 8'h00);
  assign fail_mask  = mask_q;
  assign fail_count = fcnt_q;

`ifdef XOR_BIST_CAPTURE_EN
  logic signed [Q_W-1:0] cap_mem_q [8];
  logic signed [Q_W-1:0] cap_data_q;

  // Raw network output per pattern, sampled on the same cycle it is judged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) cap_mem_q[i] <= ZERO;
      cap_data_q <= ZERO;
    end else begin
      if (state_q == S_CHECK) cap_mem_q[pat_q] <= result;
      cap_data_q <= cap_mem_q[cap_addr];
    end
  end

  assign cap_data = cap_data_q;
`endif
endmodule
